simple_and_gate: RTL and testbench

//  Parameterised bitwise 2-input AND cell. Combinational result f = a & b (truth table 00->0, 01->0, 10->0, 11->1 per bit),

---
 rtl/simple_and_gate_pkg.sv | 11 +
 rtl/simple_and_gate_stage.sv | 37 +++
 rtl/simple_and_gate.sv | 83 ++++++++
 tb/tb_simple_and_gate.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_and_gate_pkg.sv
// rtl/simple_and_gate_pkg.sv - shared limits and helpers for the AND cell
package simple_and_gate_pkg;

    localparam int MAX_PIPE = 4;
    localparam int CNT_W    = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/simple_and_gate_stage.sv
// rtl/simple_and_gate_stage.sv - one register of the valid-qualified result pipeline
module simple_and_gate_stage
    import simple_and_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // The valid bit is the load enable: data holds while nothing valid arrives.
    always_comb begin
        vld_d = vld_i;
        dat_d = vld_i ? dat_i : dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/simple_and_gate.sv
// rtl/simple_and_gate.sv - bitwise AND cell with registered, valid-qualified copy and flags
// Optional all-ones result counter enabled by defining SIMPLE_AND_GATE_STATS_EN.
module simple_and_gate
    import simple_and_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_vld,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             f_vld,
    output logic             all_one,
    output logic             any_one
`ifdef SIMPLE_AND_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] ones_cnt
`endif
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
    } stage_t;

    if (PIPE < 1 || PIPE > MAX_PIPE || WIDTH < 1) begin : g_bad_param
        $error("simple_and_gate: PIPE must be 1..%0d and WIDTH >= 1", MAX_PIPE);
    end

    logic             vld_c [PIPE+1];
    logic [WIDTH-1:0] dat_c [PIPE+1];
    stage_t           out_s;

    assign f        = a & b;
    assign vld_c[0] = in_vld;
    assign dat_c[0] = a & b;

    for (genvar i = 0; i < PIPE; i++) begin : g_stage
        simple_and_gate_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .vld_i (vld_c[i]),
            .dat_i (dat_c[i]),
            .vld_o (vld_c[i+1]),
            .dat_o (dat_c[i+1])
        );
    end

    assign out_s   = '{vld: vld_c[PIPE], dat: dat_c[PIPE]};
    assign f_q     = out_s.dat;
    assign f_vld   = out_s.vld;
    assign all_one = out_s.vld & (&out_s.dat);
    assign any_one = out_s.vld & (|out_s.dat);

`ifdef SIMPLE_AND_GATE_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bump;

    // Look at the last stage's inputs so the count moves on the same edge the
    // all-ones result appears at the outputs.
    always_comb begin
        bump  = vld_c[PIPE-1] & (&dat_c[PIPE-1]);
        cnt_d = bump ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_simple_and_gate.sv
// tb/tb_simple_and_gate.sv - randomized self-checking bench for simple_and_gate
// Exercises the ones_cnt output when SIMPLE_AND_GATE_STATS_EN is defined.
module tb_simple_and_gate;

    localparam int P8 = 3;
    localparam int P1 = 2;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
    } samp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       v8 = 1'b0;
    logic [7:0] f8, fq8;
    logic       fv8, ao8, an8;
    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       f1, fq1, fv1, ao1, an1;
`ifdef SIMPLE_AND_GATE_STATS_EN
    logic [15:0] oc8, oc1;
`endif

    int checks = 0;
    int errors = 0;

    samp_t      h8[$], h1[$];
    logic [7:0] held8 = '0, held1 = '0;
    logic       ev8 = 1'b0, ev1 = 1'b0;
    int         cnt8 = 0, cnt1 = 0;

    always #5 clk = ~clk;

    simple_and_gate #(.WIDTH(8), .PIPE(P8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_vld(v8),
        .f(f8), .f_q(fq8), .f_vld(fv8), .all_one(ao8), .any_one(an8)
`ifdef SIMPLE_AND_GATE_STATS_EN
        , .ones_cnt(oc8)
`endif
    );

    simple_and_gate #(.WIDTH(1), .PIPE(P1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_vld(v1),
        .f(f1), .f_q(fq1), .f_vld(fv1), .all_one(ao1), .any_one(an1)
`ifdef SIMPLE_AND_GATE_STATS_EN
        , .ones_cnt(oc1)
`endif
    );

    // Reference: each sample leaves exactly PIPE edges after it was taken; the
    // output holds the most recent valid sample that has left; reset forgets all.
    task automatic tick();
        samp_t s;
        @(posedge clk);
        if (rst) begin
            h8.delete(); h1.delete();
            held8 = '0; held1 = '0; ev8 = 1'b0; ev1 = 1'b0; cnt8 = 0; cnt1 = 0;
        end else begin
            h8.push_back('{vld: v8, dat: a8 & b8});
            h1.push_back('{vld: v1, dat: {7'd0, a1 & b1}});
            ev8 = 1'b0;
            if (h8.size() == P8) begin
                s = h8.pop_front();
                ev8 = s.vld;
                if (s.vld) held8 = s.dat;
            end
            ev1 = 1'b0;
            if (h1.size() == P1) begin
                s = h1.pop_front();
                ev1 = s.vld;
                if (s.vld) held1 = s.dat;
            end
            if (ev8 && held8 == 8'hFF && cnt8 < 65535) cnt8++;
            if (ev1 && held1[0] && cnt1 < 65535) cnt1++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick(); tick();
        checks++; if (fq8 !== 8'h00) begin errors++; $display("FAIL reset_fq8 got %h want 00", fq8); end
        checks++; if ({fv8, ao8, an8} !== 3'b000) begin errors++; $display("FAIL reset_flags8 got %b want 000", {fv8, ao8, an8}); end
        checks++; if ({fq1, fv1, ao1, an1} !== 4'b0000) begin errors++; $display("FAIL reset_out1 got %b want 0000", {fq1, fv1, ao1, an1}); end
        checks++; if (f8 !== 8'hFF) begin errors++; $display("FAIL reset_f_comb got %h want ff", f8); end
        rst = 1'b0; v8 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_truth_table();
        logic tt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            v1 = (i < 4);
            if (i < 4) begin
                a1 = i[1]; b1 = i[0];
                #1;
                checks++; if (f1 !== tt[i]) begin errors++; $display("FAIL tt_f ab=%0d got %b want %b", i, f1, tt[i]); end
            end
            tick();
            checks++; if ({fv1, fq1} !== {ev1, held1[0]}) begin errors++; $display("FAIL tt_fq step=%0d got %b%b want %b%b", i, fv1, fq1, ev1, held1[0]); end
            checks++; if ({ao1, an1} !== {2{ev1 & held1[0]}}) begin errors++; $display("FAIL tt_flags step=%0d got %b want %b", i, {ao1, an1}, {2{ev1 & held1[0]}}); end
        end
    endtask

    task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xf);
        a8 = xa; b8 = xb; v8 = 1'b1;
        #1;
        checks++; if (f8 !== xf) begin errors++; $display("FAIL dir_f %h&%h got %h want %h", xa, xb, f8, xf); end
        tick();
        v8 = 1'b0; a8 = $urandom; b8 = $urandom;
        repeat (P8 - 1) tick();
        checks++; if ({fv8, fq8} !== {1'b1, xf}) begin errors++; $display("FAIL dir_fq got %b/%h want 1/%h", fv8, fq8, xf); end
        checks++; if ({ao8, an8} !== {xf == 8'hFF, xf != 8'h00}) begin errors++; $display("FAIL dir_flags got %b want %b", {ao8, an8}, {xf == 8'hFF, xf != 8'h00}); end
        tick();
        checks++; if ({fv8, ao8, an8, fq8} !== {3'b000, xf}) begin errors++; $display("FAIL dir_after got %b/%h want 000/%h", {fv8, ao8, an8}, fq8, xf); end
    endtask

    task automatic test_directed();
        run8(8'hF0, 8'h3C, 8'h30);
        run8(8'hFF, 8'hFF, 8'hFF);
        run8(8'hAA, 8'h55, 8'h00);
    endtask

    task automatic test_hold();
        v8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a8 = $urandom; b8 = $urandom;
            #1;
            checks++; if (f8 !== (a8 & b8)) begin errors++; $display("FAIL hold_f got %h want %h", f8, a8 & b8); end
            tick();
            checks++; if ({fv8, ao8, an8, fq8} !== {3'b000, held8}) begin errors++; $display("FAIL hold_out got %b/%h want 000/%h", {fv8, ao8, an8}, fq8, held8); end
        end
    endtask

    task automatic cmp_all(input string tag);
        checks++;
        if ({fv8, fq8} !== {ev8, held8} || {ao8, an8} !== {ev8 & (held8 == 8'hFF), ev8 & (held8 != 8'h00)}) begin
            errors++; $display("FAIL %s_w8 got %b/%h/%b want %b/%h/%b", tag, fv8, fq8, {ao8, an8}, ev8, held8, {ev8 & (held8 == 8'hFF), ev8 & (held8 != 8'h00)});
        end
        checks++;
        if ({fv1, fq1, ao1, an1} !== {ev1, held1[0], {2{ev1 & held1[0]}}}) begin
            errors++; $display("FAIL %s_w1 got %b want %b", tag, {fv1, fq1, ao1, an1}, {ev1, held1[0], {2{ev1 & held1[0]}}});
        end
`ifdef SIMPLE_AND_GATE_STATS_EN
        checks++;
        if (oc8 !== 16'(cnt8) || oc1 !== 16'(cnt1)) begin
            errors++; $display("FAIL %s_cnt got %0d/%0d want %0d/%0d", tag, oc8, oc1, cnt8, cnt1);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            a8 = $urandom; b8 = $urandom; v8 = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin a8 = 8'hFF; b8 = 8'hFF; end
            a1 = $urandom; b1 = $urandom; v1 = $urandom_range(0, 1);
            #1;
            checks++; if (f8 !== (a8 & b8) || f1 !== (a1 & b1)) begin errors++; $display("FAIL rand_f got %h/%b want %h/%b", f8, f1, a8 & b8, a1 & b1); end
            tick();
            cmp_all("rand");
        end
    endtask

    task automatic test_reset_mid();
        v8 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a8 = $urandom | 8'h01; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
            tick();
        end
        rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        checks++; if ({fv8, fq8, fv1, fq1} !== 11'd0) begin errors++; $display("FAIL mid_rst got %b/%h/%b/%b want all 0", fv8, fq8, fv1, fq1); end
        rst = 1'b0; v8 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({fv8, fv1} !== 2'b00) begin errors++; $display("FAIL mid_stale cyc=%0d got %b want 00", i, {fv8, fv1}); end
        end
        a8 = 8'h5A; b8 = 8'h5A; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        for (int i = 1; i <= P8; i++) begin
            if (i > 1) tick();
            checks++; if ({fv8, fq8} !== ((i == P8) ? 9'h15A : 9'h000)) begin errors++; $display("FAIL mid_lat edge=%0d got %b/%h want %0d/%h", i, fv8, fq8, i == P8, (i == P8) ? 8'h5A : 8'h00); end
        end
    endtask

    task automatic test_back_to_back();
        v8 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a8 = $urandom; b8 = (i % 3 == 0) ? 8'hFF : 8'($urandom);
            a1 = $urandom; b1 = $urandom;
            tick();
            cmp_all("b2b");
        end
        v8 = 1'b0; v1 = 1'b0;
    endtask

`ifdef SIMPLE_AND_GATE_STATS_EN
    task automatic test_stats();
        rst = 1'b1; tick(); rst = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v8 = 1'b1; v1 = 1'b1; tick();
            v8 = 1'b0; v1 = 1'b0; tick();
        end
        repeat (P8) tick();
        checks++; if (oc8 !== 16'd5 || oc1 !== 16'd5) begin errors++; $display("FAIL stats_five got %0d/%0d want 5/5", oc8, oc1); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (oc8 !== 16'd0 || oc1 !== 16'd0) begin errors++; $display("FAIL stats_rst got %0d/%0d want 0/0", oc8, oc1); end
        v8 = 1'b1; v1 = 1'b1;
        repeat (65540) tick();
        checks++; if (oc8 !== 16'hFFFF || oc1 !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h/%h want ffff/ffff", oc8, oc1); end
        cmp_all("sat");
        v8 = 1'b0; v1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_directed();
        test_hold();
        test_random();
        test_reset_mid();
        test_back_to_back();
`ifdef SIMPLE_AND_GATE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
